// File: rtl/sync_account_requester_pkg.sv
// Shared types for the barrier synchronization requester: barrier/count types,
// account and release message formats, and the per-thread requester state.
`ifndef TILE_COUNT
`define TILE_COUNT 16
`endif

package sync_account_requester_pkg;

  localparam int unsigned TILE_COUNT = `TILE_COUNT;
  localparam int unsigned TILE_ID_W  = (TILE_COUNT > 1) ? $clog2(TILE_COUNT) : 1;
  localparam int unsigned BARRIER_W  = 8;
  localparam int unsigned CNT_W      = 8;

  typedef logic [BARRIER_W-1:0] barrier_t;
  typedef logic [CNT_W-1:0]     cnt_barrier_t;
  typedef logic [TILE_ID_W-1:0] tile_id_t;

  typedef struct packed {
    barrier_t     id_barrier;
    cnt_barrier_t cnt_setup;
    tile_id_t     tile_id_source;
  } sync_account_message_t;

  typedef struct packed {
    barrier_t id_barrier;
  } sync_release_message_t;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    WAIT_RELEASE
  } sar_state_t;

  // Barriers are homed by their low ID bits.
  function automatic tile_id_t home_tile(input barrier_t id);
    return id[TILE_ID_W-1:0];
  endfunction

endpackage

// File: rtl/sync_account_requester_rr_arbiter.sv
// Round-robin arbiter: one-hot grant over N requests; the priority pointer
// moves to grant+1 whenever update_i is asserted.
module rr_arbiter #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req_i,
  input  logic         update_i,
  output logic [N-1:0] grant_o
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] gnt_idx;
  logic          found;

  // First pass scans from the pointer upward; second pass wraps to index 0.
  always_comb begin
    grant_o = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && (j >= 32'(ptr_q)) && req_i[j]) begin
        grant_o[j] = 1'b1;
        gnt_idx    = IW'(j);
        found      = 1'b1;
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && req_i[j]) begin
        grant_o[j] = 1'b1;
        gnt_idx    = IW'(j);
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update_i && found) begin
      ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sync_account_requester.sv
// Tile-side barrier requester: stalls requesting threads, sends one account
// message per request, un-stalls threads on release. Logging: SYNC_ACCOUNT_REQUESTER_DISPLAY_EN.
module sync_account_requester
  import sync_account_requester_pkg::*;
#(
  parameter int unsigned TILE_ID     = 0,
  parameter int unsigned THREAD_NUMB = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         core_bar_valid,
  input  logic [$clog2(THREAD_NUMB)-1:0] core_bar_thread_id,
  input  barrier_t                     core_bar_id,
  input  cnt_barrier_t                 core_bar_cnt,
  output logic [THREAD_NUMB-1:0]       sar_thread_stop,
  output sync_account_message_t        sar_account_mess,
  output logic [TILE_ID_W-1:0]         sar_account_dest,
  output logic                         sar_account_valid,
  input  logic                         ni_account_almost_full,
  input  sync_release_message_t        ni_release_mess,
  input  logic                         ni_release_valid,
  output logic                         sar_release_consumed
);

  localparam int unsigned TID_W = $clog2(THREAD_NUMB);

  sar_state_t   state_q [THREAD_NUMB];
  sar_state_t   state_d [THREAD_NUMB];
  barrier_t     id_q    [THREAD_NUMB];
  barrier_t     id_d    [THREAD_NUMB];
  cnt_barrier_t cnt_q   [THREAD_NUMB];
  cnt_barrier_t cnt_d   [THREAD_NUMB];

  logic [THREAD_NUMB-1:0] pending;
  logic [THREAD_NUMB-1:0] arb_req;
  logic [THREAD_NUMB-1:0] grant;

  sync_account_message_t mess_d, mess_q;
  tile_id_t              dest_q;
  logic                  valid_q;

  always_comb begin
    for (int unsigned i = 0; i < THREAD_NUMB; i++) begin
      pending[i]         = (state_q[i] == PENDING);
      sar_thread_stop[i] = (state_q[i] != IDLE);
    end
  end

  assign arb_req = pending & {THREAD_NUMB{!ni_account_almost_full}};

  rr_arbiter #(
    .N (THREAD_NUMB)
  ) u_rr_arbiter (
    .clk      (clk),
    .reset    (reset),
    .req_i    (arb_req),
    .update_i (|grant),
    .grant_o  (grant)
  );

  // A thread only accepts a request from IDLE, so a release landing on the
  // same thread in the same cycle always takes precedence.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    for (int unsigned i = 0; i < THREAD_NUMB; i++) begin
      case (state_q[i])
        IDLE: begin
          if (core_bar_valid && (core_bar_thread_id == TID_W'(i))) begin
            state_d[i] = PENDING;
            id_d[i]    = core_bar_id;
            cnt_d[i]   = core_bar_cnt;
          end
        end
        PENDING: begin
          if (grant[i]) state_d[i] = WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (ni_release_valid && (ni_release_mess.id_barrier == id_q[i]))
            state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    mess_d = '0;
    for (int unsigned i = 0; i < THREAD_NUMB; i++) begin
      if (grant[i]) begin
        mess_d.id_barrier     = id_q[i];
        mess_d.cnt_setup      = cnt_q[i];
        mess_d.tile_id_source = tile_id_t'(TILE_ID);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '{default: IDLE};
      id_q    <= '{default: '0};
      cnt_q   <= '{default: '0};
      mess_q  <= '0;
      dest_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      valid_q <= |grant;
      if (|grant) begin
        mess_q <= mess_d;
        dest_q <= home_tile(mess_d.id_barrier);
      end
    end
  end

  assign sar_account_mess     = mess_q;
  assign sar_account_dest     = dest_q;
  assign sar_account_valid    = valid_q;
  assign sar_release_consumed = ni_release_valid;

`ifdef SYNC_ACCOUNT_REQUESTER_DISPLAY_EN
  logic [THREAD_NUMB-1:0] released_mask;

  always_comb begin
    released_mask = '0;
    for (int unsigned i = 0; i < THREAD_NUMB; i++) begin
      released_mask[i] = ni_release_valid && (state_q[i] == WAIT_RELEASE) &&
                         (id_q[i] == ni_release_mess.id_barrier);
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      if (core_bar_valid && (state_q[core_bar_thread_id] == IDLE)) begin
        $display("[SAR %0d] request thread %0d id %0d cnt %0d",
                 TILE_ID, core_bar_thread_id, core_bar_id, core_bar_cnt);
      end
      if (valid_q) begin
        $display("[SAR %0d] account id %0d tile %0d cnt %0d",
                 TILE_ID, mess_q.id_barrier, mess_q.tile_id_source, mess_q.cnt_setup);
      end
      if (ni_release_valid) begin
        $display("[SAR %0d] release id %0d threads %b",
                 TILE_ID, ni_release_mess.id_barrier, released_mask);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_sync_account_requester.sv
// Directed bench for sync_account_requester with a scoreboard of expected
// account messages checked whenever the DUT sends.
module tb_sync_account_requester;
  import sync_account_requester_pkg::*;

  localparam int unsigned TN  = 8;
  localparam int unsigned TID = 3;

  logic                  clk;
  logic                  reset;
  logic                  core_bar_valid;
  logic [2:0]            core_bar_thread_id;
  barrier_t              core_bar_id;
  cnt_barrier_t          core_bar_cnt;
  logic [TN-1:0]         sar_thread_stop;
  sync_account_message_t sar_account_mess;
  logic [TILE_ID_W-1:0]  sar_account_dest;
  logic                  sar_account_valid;
  logic                  ni_account_almost_full;
  sync_release_message_t ni_release_mess;
  logic                  ni_release_valid;
  logic                  sar_release_consumed;

  sync_account_requester #(
    .TILE_ID     (TID),
    .THREAD_NUMB (TN)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .core_bar_valid         (core_bar_valid),
    .core_bar_thread_id     (core_bar_thread_id),
    .core_bar_id            (core_bar_id),
    .core_bar_cnt           (core_bar_cnt),
    .sar_thread_stop        (sar_thread_stop),
    .sar_account_mess       (sar_account_mess),
    .sar_account_dest       (sar_account_dest),
    .sar_account_valid      (sar_account_valid),
    .ni_account_almost_full (ni_account_almost_full),
    .ni_release_mess        (ni_release_mess),
    .ni_release_valid       (ni_release_valid),
    .sar_release_consumed   (sar_release_consumed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    sync_account_message_t mess;
    tile_id_t              dest;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_exp(input int unsigned id, input int unsigned cnt);
    exp_t e;
    e.mess.id_barrier     = barrier_t'(id);
    e.mess.cnt_setup      = cnt_barrier_t'(cnt);
    e.mess.tile_id_source = tile_id_t'(TID);
    e.dest                = tile_id_t'(id % TILE_COUNT);
    sb_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (sar_account_valid === 1'b1) begin
      n_assert++;
      assert (sb_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_send: observed mess 0x%0h expected no send", sar_account_mess);
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("account_mess", 32'(sar_account_mess), 32'(e.mess));
        chk("account_dest", 32'(sar_account_dest), 32'(e.dest));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input int unsigned tid, input int unsigned id,
                         input int unsigned cnt, input bit expect_send);
    core_bar_valid     = 1'b1;
    core_bar_thread_id = 3'(tid);
    core_bar_id        = barrier_t'(id);
    core_bar_cnt       = cnt_barrier_t'(cnt);
    if (expect_send) push_exp(id, cnt);
    step();
    core_bar_valid = 1'b0;
  endtask

  task automatic release_id(input int unsigned id);
    ni_release_valid           = 1'b1;
    ni_release_mess.id_barrier = barrier_t'(id);
    @(negedge clk);
    chk("release_consumed", 32'(sar_release_consumed), 32'd1);
    step();
    ni_release_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset                  = 1'b1;
    core_bar_valid         = 1'b0;
    core_bar_thread_id     = '0;
    core_bar_id            = '0;
    core_bar_cnt           = '0;
    ni_account_almost_full = 1'b0;
    ni_release_mess        = '0;
    ni_release_valid       = 1'b0;

    // Reset values
    repeat (3) step();
    @(negedge clk);
    chk("rst_stop",     32'(sar_thread_stop),      32'h0);
    chk("rst_valid",    32'(sar_account_valid),    32'h0);
    chk("rst_mess",     32'(sar_account_mess),     32'h0);
    chk("rst_dest",     32'(sar_account_dest),     32'h0);
    chk("rst_consumed", 32'(sar_release_consumed), 32'h0);
    step();
    reset = 1'b0;
    repeat (2) step();

    // Single request: stop at t+1, send at t+2 for one cycle
    request(2, 5, 4, 1'b1);
    @(negedge clk);
    chk("t1_stop_t1",  32'(sar_thread_stop),   32'h04);
    chk("t1_valid_t1", 32'(sar_account_valid), 32'h0);
    step();
    @(negedge clk);
    chk("t1_valid_t2", 32'(sar_account_valid), 32'h1);
    step();
    @(negedge clk);
    chk("t1_valid_t3", 32'(sar_account_valid), 32'h0);
    chk("t1_stop_wait", 32'(sar_thread_stop),  32'h04);

    // Round-robin order 0,1,3 from pointer 0, back to back
    do_reset();
    ni_account_almost_full = 1'b1;
    request(0, 10, 1, 1'b1);
    request(1, 11, 2, 1'b1);
    request(3, 12, 3, 1'b1);
    @(negedge clk);
    chk("t2_stop",  32'(sar_thread_stop),   32'h0B);
    chk("t2_valid", 32'(sar_account_valid), 32'h0);
    step();
    ni_account_almost_full = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("t2_burst_valid", 32'(sar_account_valid), 32'h1);
    end
    step();
    @(negedge clk);
    chk("t2_burst_end", 32'(sar_account_valid), 32'h0);

    // Almost-full hold; pointer after thread 3 favours thread 5 over 2
    step();
    ni_account_almost_full = 1'b1;
    request(5, 20, 5, 1'b1);
    request(2, 21, 6, 1'b1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("t3_af_hold", 32'(sar_account_valid), 32'h0);
      step();
    end
    @(negedge clk);
    chk("t3_stop", 32'(sar_thread_stop), 32'h2F);
    step();
    ni_account_almost_full = 1'b0;
    step();
    @(negedge clk);
    chk("t3_send0", 32'(sar_account_valid), 32'h1);
    step();
    @(negedge clk);
    chk("t3_send1", 32'(sar_account_valid), 32'h1);
    step();
    @(negedge clk);
    chk("t3_send_end", 32'(sar_account_valid), 32'h0);

    // Release matching: 4,6 on 7 clear; 5 on 8 and pending 7 on 7 stay
    do_reset();
    request(4, 7, 1, 1'b1);
    request(5, 8, 2, 1'b1);
    request(6, 7, 3, 1'b1);
    repeat (3) step();
    ni_account_almost_full = 1'b1;
    request(7, 7, 4, 1'b1);
    @(negedge clk);
    chk("t4_stop_before", 32'(sar_thread_stop), 32'hF0);
    step();
    release_id(7);
    @(negedge clk);
    chk("t4_stop_after7",  32'(sar_thread_stop),      32'hA0);
    chk("t4_consumed_off", 32'(sar_release_consumed), 32'h0);
    step();
    release_id(9);
    @(negedge clk);
    chk("t4_stop_after9", 32'(sar_thread_stop), 32'hA0);
    step();
    ni_account_almost_full = 1'b0;
    repeat (3) step();
    release_id(8);
    @(negedge clk);
    chk("t4_stop_after8", 32'(sar_thread_stop), 32'h80);
    step();
    release_id(7);
    @(negedge clk);
    chk("t4_stop_final", 32'(sar_thread_stop), 32'h00);
    step();

    // Re-request while waiting is ignored; reset mid-wait drops everything
    request(1, 3, 2, 1'b1);
    repeat (3) step();
    request(1, 4, 9, 1'b0);
    repeat (3) step();
    @(negedge clk);
    chk("t5_stop_wait", 32'(sar_thread_stop), 32'h02);
    step();
    ni_account_almost_full = 1'b1;
    request(2, 6, 1, 1'b0);
    reset = 1'b1;
    #1;
    chk("t5_async_stop",  32'(sar_thread_stop),   32'h00);
    chk("t5_async_valid", 32'(sar_account_valid), 32'h0);
    step();
    reset = 1'b0;
    ni_account_almost_full = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge clk);
      chk("t5_post_rst_valid", 32'(sar_account_valid), 32'h0);
      chk("t5_post_rst_stop",  32'(sar_thread_stop),   32'h00);
    end
    step();

    // Release and new request on the same thread in one cycle: release wins
    request(1, 3, 2, 1'b1);
    repeat (3) step();
    core_bar_valid             = 1'b1;
    core_bar_thread_id         = 3'd1;
    core_bar_id                = barrier_t'(10);
    core_bar_cnt               = cnt_barrier_t'(1);
    ni_release_valid           = 1'b1;
    ni_release_mess.id_barrier = barrier_t'(3);
    @(negedge clk);
    chk("t6_consumed", 32'(sar_release_consumed), 32'h1);
    step();
    core_bar_valid   = 1'b0;
    ni_release_valid = 1'b0;
    @(negedge clk);
    chk("t6_stop_clear", 32'(sar_thread_stop), 32'h00);
    repeat (4) step();
    @(negedge clk);
    chk("t6_stop_idle", 32'(sar_thread_stop), 32'h00);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
